// File: rtl/video_pattern_gen.sv
// video_pattern_gen
// Raster video source: generates parameterised line/frame timing and one of
// four 8-bit luminance test patterns for the FIR filter path.
//
// Ports
//   clk      in   pixel clock
//   rst      in   asynchronous reset, active low
//   en_i     in   advance enable; low freezes counters and all outputs
//   pat_i    in   [1:0] pattern select, sampled at frame start
//   level_i  in   [7:0] flat-field level for pattern 3, sampled with pat_i
//   y_o      out  [7:0] luminance, 0 outside the active region
//   dv_o     out  data valid (active region)
//   hs_o     out  horizontal sync, active high
//   vs_o     out  vertical sync, active high (whole lines)
//   sof_o    out  one-enabled-cycle pulse at pixel (0,0)
//   x_o      out  [10:0] pixel column, 0 in blanking
//   y_idx_o  out  [9:0] pixel row, 0 in blanking
module video_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [1:0]  pat_i,
    input  logic [7:0]  level_i,
    output logic [7:0]  y_o,
    output logic        dv_o,
    output logic        hs_o,
    output logic        vs_o,
    output logic        sof_o,
    output logic [10:0] x_o,
    output logic [9:0]  y_idx_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST_C   = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT_C    = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_B_C = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_E_C = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST_C   = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT_C    = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_B_C = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_E_C = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] h_r;
    logic [10:0] v_r;
    logic [1:0]  pat_r;
    logic [7:0]  level_r;

    logic [11:0] h_next_s;
    logic [10:0] v_next_s;
    logic        active_s;
    logic        hsync_s;
    logic        vsync_s;
    logic        sof_s;
    logic [1:0]  pat_eff_s;
    logic [7:0]  level_eff_s;
    logic [7:0]  pix_s;
    logic [10:0] x_s;
    logic [9:0]  row_s;

    // Raster counter advance: h wraps at line end and carries into v.
    always_comb begin
        h_next_s = h_r + 12'd1;
        v_next_s = v_r;
        if (h_r == H_LAST_C) begin
            h_next_s = 12'd0;
            if (v_r == V_LAST_C) begin
                v_next_s = 11'd0;
            end else begin
                v_next_s = v_r + 11'd1;
            end
        end else begin
            v_next_s = v_r;
        end
    end

    // Decode of the current counter state into timing flags and pixel value.
    // At (0,0) the pattern inputs are used directly so the new selection
    // applies to the very first pixel of the frame.
    always_comb begin
        active_s    = (h_r < H_ACT_C) && (v_r < V_ACT_C);
        hsync_s     = (h_r >= H_SYNC_B_C) && (h_r < H_SYNC_E_C);
        vsync_s     = (v_r >= V_SYNC_B_C) && (v_r < V_SYNC_E_C);
        sof_s       = (h_r == 12'd0) && (v_r == 11'd0);
        pat_eff_s   = sof_s ? pat_i : pat_r;
        level_eff_s = sof_s ? level_i : level_r;
        case (pat_eff_s)
            2'd0:    pix_s = h_r[7:0];
            2'd1:    pix_s = v_r[7:0];
            2'd2:    pix_s = (h_r[5] ^ v_r[5]) ? 8'hFF : 8'h00;
            2'd3:    pix_s = level_eff_s;
            default: pix_s = 8'h00;
        endcase
        if (active_s) begin
            x_s   = h_r[10:0];
            row_s = v_r[9:0];
        end else begin
            pix_s = 8'h00;
            x_s   = 11'd0;
            row_s = 10'd0;
        end
    end

    // Counter and frame-pattern latch state; frozen while en_i is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_r     <= 12'd0;
            v_r     <= 11'd0;
            pat_r   <= 2'd0;
            level_r <= 8'd0;
        end else if (en_i) begin
            h_r <= h_next_s;
            v_r <= v_next_s;
            if (sof_s) begin
                pat_r   <= pat_i;
                level_r <= level_i;
            end else begin
                pat_r   <= pat_r;
                level_r <= level_r;
            end
        end else begin
            h_r     <= h_r;
            v_r     <= v_r;
            pat_r   <= pat_r;
            level_r <= level_r;
        end
    end

    // Registered outputs reflecting the counter state before each enabled edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_o     <= 8'd0;
            dv_o    <= 1'b0;
            hs_o    <= 1'b0;
            vs_o    <= 1'b0;
            sof_o   <= 1'b0;
            x_o     <= 11'd0;
            y_idx_o <= 10'd0;
        end else if (en_i) begin
            y_o     <= pix_s;
            dv_o    <= active_s;
            hs_o    <= hsync_s;
            vs_o    <= vsync_s;
            sof_o   <= sof_s;
            x_o     <= x_s;
            y_idx_o <= row_s;
        end else begin
            y_o     <= y_o;
            dv_o    <= dv_o;
            hs_o    <= hs_o;
            vs_o    <= vs_o;
            sof_o   <= sof_o;
            x_o     <= x_o;
            y_idx_o <= y_idx_o;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen on a 14x7 raster (98 clocks/frame).
// The reference model derives every pixel from the count of enabled edges
// since reset, using plain division/modulo on the raster dimensions.
module tb_video_pattern_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  pat = 2'd0;
    logic [7:0]  lvl = 8'd0;
    logic [7:0]  y;
    logic        dv, hs, vs, sof;
    logic [10:0] x;
    logic [9:0]  yi;
    logic [32:0] got_vec;

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst), .en_i(en), .pat_i(pat), .level_i(lvl),
        .y_o(y), .dv_o(dv), .hs_o(hs), .vs_o(vs), .sof_o(sof),
        .x_o(x), .y_idx_o(yi)
    );

    always #5 clk = ~clk;

    assign got_vec = {y, dv, hs, vs, sof, x, yi};

    int errors = 0;
    int checks = 0;

    // reference model state
    int          n_edges = 0;
    int          m_pat = 0;
    int          m_lvl = 0;
    int          last_h = -1;
    int          last_v = -1;
    logic [32:0] exp_vec = 33'd0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] pix_model(input int h, input int v, input int p, input int l);
        logic [7:0]  yy;
        logic        a, hsy, vsy, s;
        logic [10:0] xx;
        logic [9:0]  rr;
        a   = (h < HA) && (v < VA);
        hsy = (h >= HA + HF) && (h < HA + HF + HS);
        vsy = (v >= VA + VF) && (v < VA + VF + VS);
        s   = (h == 0) && (v == 0);
        yy  = 8'd0;
        xx  = 11'd0;
        rr  = 10'd0;
        if (a) begin
            xx = 11'(h);
            rr = 10'(v);
            case (p)
                0:       yy = 8'(h % 256);
                1:       yy = 8'(v % 256);
                2:       yy = (((h / 32) % 2) != ((v / 32) % 2)) ? 8'hFF : 8'h00;
                default: yy = 8'(l);
            endcase
        end
        return {yy, a, hsy, vsy, s, xx, rr};
    endfunction

    // Predict the effect of the coming edge, then sample at the next negedge.
    task automatic step();
        int pos, h, v;
        if (en && rst) begin
            pos = n_edges % FT;
            h   = pos % HT;
            v   = pos / HT;
            if (pos == 0) begin
                m_pat = int'(pat);
                m_lvl = int'(lvl);
            end
            exp_vec = pix_model(h, v, m_pat, m_lvl);
            last_h  = h;
            last_v  = v;
            n_edges++;
        end
        @(negedge clk);
        check_eq("pix", 64'(got_vec), 64'(exp_vec));
    endtask

    task automatic model_reset();
        n_edges = 0;
        m_pat   = 0;
        m_lvl   = 0;
        last_h  = -1;
        last_v  = -1;
        exp_vec = 33'd0;
    endtask

    initial begin
        int dv_cnt, hs_cnt, hs_pulses, vs_cnt, sof_cnt, flat_cnt, blank_nz;
        int sof_at;
        logic hs_prev;
        bit found;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_state", 64'(got_vec), 64'd0);
        rst = 1'b1;
        en  = 1'b1;
        pat = 2'd0;

        // first frame, horizontal ramp, with timing statistics
        dv_cnt = 0; hs_cnt = 0; hs_pulses = 0; vs_cnt = 0; sof_cnt = 0;
        hs_prev = 1'b0;
        for (int i = 0; i < FT; i++) begin
            lvl = 8'($urandom);
            step();
            if (i == 0) begin
                check_eq("first_sof", 64'(sof), 64'd1);
                check_eq("first_y", 64'(y), 64'd0);
            end
            if (i == 7) check_eq("ramp_end", 64'(y), 64'd7);
            if (dv) dv_cnt++;
            if (hs) hs_cnt++;
            if (hs && !hs_prev) hs_pulses++;
            if (vs) vs_cnt++;
            if (sof) sof_cnt++;
            hs_prev = hs;
        end
        check_eq("dv_count", 64'(dv_cnt), 64'd32);
        check_eq("hs_cycles", 64'(hs_cnt), 64'd14);
        check_eq("hs_pulses", 64'(hs_pulses), 64'd7);
        check_eq("vs_cycles", 64'(vs_cnt), 64'd14);
        check_eq("sof_count", 64'(sof_cnt), 64'd1);

        // second frame: sof must recur exactly 98 clocks after the first
        sof_at = -1;
        sof_cnt = 0;
        for (int i = 0; i < FT; i++) begin
            step();
            if (sof) begin
                sof_cnt++;
                if (sof_at < 0) sof_at = i;
            end
        end
        check_eq("sof_period", 64'(sof_at), 64'd0);
        check_eq("sof_once", 64'(sof_cnt), 64'd1);

        // checkerboard, switched to flat 0x5A mid-frame
        pat = 2'd2;
        for (int i = 0; i < 40; i++) step();
        pat = 2'd3;
        lvl = 8'h5A;
        for (int i = 40; i < FT; i++) step();
        flat_cnt = 0;
        blank_nz = 0;
        for (int i = 0; i < FT; i++) begin
            step();
            if (dv && y == 8'h5A) flat_cnt++;
            if (!dv && y != 8'h00) blank_nz++;
        end
        check_eq("flat_pixels", 64'(flat_cnt), 64'd32);
        check_eq("flat_blank", 64'(blank_nz), 64'd0);

        // random enable, pattern and level
        for (int i = 0; i < 500; i++) begin
            en  = 1'($urandom);
            pat = 2'($urandom);
            lvl = 8'($urandom);
            step();
        end

        // vertical ramp for two frames
        en  = 1'b1;
        pat = 2'd1;
        for (int i = 0; i < 2 * FT; i++) step();

        // run to pixel (3,2), then reset asynchronously mid-frame
        found = 1'b0;
        for (int i = 0; i < 2 * FT && !found; i++) begin
            pat = 2'($urandom);
            step();
            if (last_h == 3 && last_v == 2) found = 1'b1;
        end
        check_eq("find_pix32", 64'(found), 64'd1);
        check_eq("pix32_x", 64'(x), 64'd3);
        rst = 1'b0;
        model_reset();
        #1;
        check_eq("async_clear", 64'(got_vec), 64'd0);
        @(negedge clk);
        check_eq("reset_hold", 64'(got_vec), 64'd0);
        rst = 1'b1;
        pat = 2'd0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 0) check_eq("restart_sof", 64'(sof), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
